// File: rtl/io_bridge_if.sv
// io_bridge_if
// CPU MEM-stage bus as seen by the I/O bridge.
//   Bus_addr  : byte address (master -> slave)
//   Bus_wen   : write enable, one write per cycle (master -> slave)
//   Bus_wdata : write data (master -> slave)
//   Bus_rdata : combinational read data (slave -> master)
interface io_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/io_bridge.sv
// io_bridge
// Memory-mapped bridge between the CPU MEM-stage bus, the DRAM and the board
// I/O. Addresses with [31:12]==FFFFF are I/O, everything else goes to DRAM.
// Read data is combinational so the MEM stage sees it in the same cycle.
//
// Optional feature macro: IO_TIMER_EN
//   defined   -> TCNT (FFFF_F020) / TDIV (FFFF_F024) timer is built
//   undefined -> those addresses behave as unmapped (read 0, writes ignored)
//
// Ports:
//   cpu_clk, cpu_rst : clock, synchronous active-high reset
//   bus              : CPU bus (slave side of io_bridge_if)
//   dram_addr/wen/wdata/rdata : DRAM word port (async read data)
//   sw, button       : raw board inputs, 2-flop synchronised
//   led              : LED drive, active-high
//   dig_en, seg      : 8-digit seven-segment display, both active-low
module io_bridge #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  io_bridge_if.slave  bus,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;

  // ---------------- address decode / DRAM pass-through ----------------
  logic io_sel;
  logic wr_dig, wr_led;

  assign io_sel     = (bus.Bus_addr[31:12] == 20'hFFFFF);
  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_wdata = bus.Bus_wdata;
  assign dram_wen   = bus.Bus_wen & ~io_sel;

  assign wr_dig = bus.Bus_wen && (bus.Bus_addr == ADDR_DIG);
  assign wr_led = bus.Bus_wen && (bus.Bus_addr == ADDR_LED);

  // ---------------- peripheral registers ----------------
  logic [31:0] dig_reg;
  logic [23:0] led_reg;
  logic [23:0] sw_meta_reg, sw_sync_reg;
  logic [4:0]  btn_meta_reg, btn_sync_reg;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_reg      <= '0;
      led_reg      <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      if (wr_dig) dig_reg <= bus.Bus_wdata;
      if (wr_led) led_reg <= bus.Bus_wdata[23:0];
      sw_meta_reg  <= sw;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= button;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  assign led = led_reg;

`ifdef IO_TIMER_EN
  // ---------------- timer ----------------
  logic        wr_tcnt, wr_tdiv;
  logic [31:0] tcnt_reg, tdiv_reg, tpre_reg;

  assign wr_tcnt = bus.Bus_wen && (bus.Bus_addr == ADDR_TCNT);
  assign wr_tdiv = bus.Bus_wen && (bus.Bus_addr == ADDR_TDIV);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      tcnt_reg <= '0;
      tdiv_reg <= '0;
      tpre_reg <= '0;
    end else begin
      // Prescaler runs 0..TDIV inclusive, so TCNT advances every TDIV+1 cycles.
      if (tpre_reg == tdiv_reg) begin
        tpre_reg <= '0;
        tcnt_reg <= tcnt_reg + 32'd1;
      end else begin
        tpre_reg <= tpre_reg + 32'd1;
      end
      // Software writes take priority over the same-cycle tick.
      if (wr_tcnt) tcnt_reg <= bus.Bus_wdata;
      if (wr_tdiv) begin
        tdiv_reg <= bus.Bus_wdata;
        tpre_reg <= '0;
      end
    end
  end
`endif

  // ---------------- read mux ----------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (!io_sel) begin
      rd_data = dram_rdata;
    end else begin
      case (bus.Bus_addr)
        ADDR_DIG:  rd_data = dig_reg;
        ADDR_LED:  rd_data = {8'h00, led_reg};
        ADDR_SW:   rd_data = {8'h00, sw_sync_reg};
        ADDR_BTN:  rd_data = {27'h0, btn_sync_reg};
`ifdef IO_TIMER_EN
        ADDR_TCNT: rd_data = tcnt_reg;
        ADDR_TDIV: rd_data = tdiv_reg;
`endif
        default:   rd_data = '0;
      endcase
    end
  end

  assign bus.Bus_rdata = rd_data;

  // ---------------- display scanner ----------------
  logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [2:0]        idx_reg, idx_next;
  logic [3:0]        dig_nib [8];
  logic [3:0]        cur_nib;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign dig_nib[gi] = dig_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_nib = dig_nib[idx_reg];

  // State register
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_next;
      idx_reg      <= idx_next;
    end
  end

  // Next state: move to the next digit on the prescaler terminal count;
  // the 3-bit index wraps 7 -> 0 naturally.
  always_comb begin
    scan_cnt_next = scan_cnt_reg + 1'b1;
    idx_next      = idx_reg;
    if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_next = '0;
      idx_next      = idx_reg + 3'd1;
    end
  end

  // Outputs: active-low digit enable and active-low hex decode, dp off.
  always_comb begin
    dig_en = ~(8'b1 << idx_reg);
    case (cur_nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped bus bridge between the CPU's MEM-stage bus port and the DRAM and board I/O. Decodes each `Bus_addr` into either the DRAM or a peripheral register, returns read data combinationally so the MEM stage sees it in the same cycle, and owns the peripheral state. The peripherals are an LED register, an 8-digit seven-segment display with its own scan state machine, a synchronised switch/button input port and an optional timer.

## Interface
Parameters:
- `SCAN_DIV`, 20000: cpu_clk cycles each display digit is held before the scanner moves on (≥2).

Ports:
- `cpu_clk` in 1: single clock; all state updates on its rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `Bus_addr` in 32: byte address from MEM stage.
- `Bus_wen` in 1: write enable, one write per cycle.
- `Bus_wdata` in 32: write data.
- `Bus_rdata` out 32: read data, combinational.
- `dram_addr` out 14: word address, equal to `Bus_addr[15:2]`.
- `dram_wen` out 1: DRAM write enable.
- `dram_wdata` out 32: equal to `Bus_wdata`.
- `dram_rdata` in 32: asynchronous DRAM read data.
- `sw` in 24: raw switches.
- `button` in 5: raw buttons.
- `led` out 24: LED drive, active-high.
- `dig_en` out 8: digit enables, active-low, one-hot-low.
- `seg` out 8: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

## Operation
Address decode:
- I/O space is `Bus_addr[31:12]==20'hFFFFF`. Everything else is DRAM.
- DRAM space: `dram_wen=Bus_wen` and `Bus_rdata=dram_rdata`.
- I/O space: `dram_wen=0`.
- I/O map, full 32-bit match:
  - `FFFF_F000` DIG, RW, 32-bit display value, nibble i shown on digit i.
  - `FFFF_F020` TCNT, RW.
  - `FFFF_F024` TDIV, RW.
  - `FFFF_F060` LED, RW, bits[23:0]; reads return zero-extended.
  - `FFFF_F070` SW, RO, synchronised `sw`, zero-extended.
  - `FFFF_F078` BTN, RO, synchronised `button`, zero-extended.
- Unmapped I/O addresses read 0; writes to them and to RO registers are ignored.

Input sync:
- `sw` and `button` pass through 2-flop synchronisers.

Display scanner:
- A prescaler counts 0..SCAN_DIV-1.
- On its terminal count, digit index `idx` (3-bit) increments and wraps 7→0.
- `dig_en = ~(8'b1 << idx)`.
- `seg` = active-low hex decode of `DIG[4*idx+3:4*idx]`, with dp=1 (off).
- Hex encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- The scanner runs continuously. A DIG write changes the displayed nibble from the next cycle, with no effect on scan position.

Timer (when compiled in):
- A prescaler counts 0..TDIV. On reaching TDIV it returns to 0 and TCNT increments (mod 2^32, FFFF_FFFF→0).
- TDIV=0 means TCNT increments every cycle.
- A TCNT write loads `Bus_wdata` and overrides a same-cycle increment.
- A TDIV write loads TDIV and clears the prescaler.

## Timing
- Reads are combinational: `Bus_rdata` is valid in the same cycle as `Bus_addr`.
- Writes commit on the rising edge where `Bus_wen=1`. The new value is readable from the next cycle.
- A read and a write to the same register in the same cycle returns the old value.
- SW/BTN reads reflect a pin change after 2 edges.
- Reset values:
  - `led`=0, DIG=0, TCNT=0, TDIV=0.
  - Both prescalers 0, `idx`=0, synchronisers 0.
  - Hence `dig_en`=8'hFE and `seg`=8'hC0.
  - `Bus_rdata` and `dram_*` are combinational and follow their inputs.
- Reset asserted mid-scan or mid-count restores all of the above on that edge. A write in the same cycle as reset is dropped.
- Scanner: each digit is held exactly SCAN_DIV cycles, so a full frame is 8·SCAN_DIV cycles.

## Configuration
- `IO_TIMER_EN` defined: TCNT/TDIV registers and timer logic are present as described above.
- `IO_TIMER_EN` undefined:
  - No timer flops are built.
  - FFFF_F020 and FFFF_F024 behave as unmapped: read 0, writes ignored.

## Test plan
- **DRAM pass-through:** write `Bus_addr=0000_0104`, `Bus_wen=1`, `Bus_wdata=DEADBEEF` → `dram_addr=14'h41`, `dram_wen=1`. With `dram_rdata=12345678` → `Bus_rdata=12345678`.
- **I/O isolation:**
  - Write `FFFF_F060` ← `00A5A5A5` → `dram_wen=0`; `led=A5A5A5` next cycle; read returns `00A5A5A5`.
  - Write `FFFF_F070` → no state change.
  - Read `FFFF_F0FC` → 0.
- **Switch sync:** `sw=24'h0F0F0F` changed at cycle t → SW read returns old value at t and t+1, and `000F0F0F` from t+2.
- **Scanner (SCAN_DIV=4):**
  - After reset, `dig_en=FE`, `seg=C0`.
  - Write DIG=`76543210`. Digit 1 (`dig_en=FD`) shows F9 from cycle 4 after reset; digit 7 (`dig_en=7F`) shows F8.
  - After 32 cycles `dig_en` returns to FE.
- **Timer (IO_TIMER_EN defined):**
  - TDIV=2 → TCNT increments every 3 cycles.
  - TCNT written to FFFF_FFFF → wraps to 0 on the next increment.
  - TCNT write coinciding with an increment → written value is held.
- **Reset mid-operation:** assert `cpu_rst` for one cycle while `idx=5` and TCNT=`1234` → next cycle `dig_en=FE`, TCNT=0, `led`=0. With IO_TIMER_EN undefined, a TCNT read returns 0.
